head_flit_extractor: RTL and testbench

- Single-stage registered flit pipeline on the router/NI ingress path, with a valid/ready handshake on both sides.
- Decodes the header fields of each head flit and holds them as stable per-packet sideband until the packet's tail flit passes.
- Tracks packet framing (head/body/tail), counts the flits in each packet, and flags framing violations.
- Flits pass through unmodified; this is the read-side counterpart of the head-flit rewrite stage.

---
 rtl/head_flit_extractor.sv | 115 +++++++++++
 tb/tb_head_flit_extractor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/head_flit_extractor.sv
// Registered flit stage that decodes head-flit fields into per-packet sideband
// and tracks head/body/tail framing, flagging framing violations.
module head_flit_extractor #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned TYPE_WIDTH  = 2,
    parameter int unsigned DEST_LSB    = 0,
    parameter int unsigned DEST_WIDTH  = 4,
    parameter int unsigned SRC_LSB     = 4,
    parameter int unsigned SRC_WIDTH   = 4,
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  flit_in,
    input  logic [TYPE_WIDTH-1:0]  flitType_in,
    input  logic                   valid_in,
    output logic                   ready_in,
    output logic [DATA_WIDTH-1:0]  flit_out,
    output logic [TYPE_WIDTH-1:0]  flitType_out,
    output logic                   valid_out,
    input  logic                   ready_out,
    output logic [DEST_WIDTH-1:0]  headDest,
    output logic [SRC_WIDTH-1:0]   headSrc,
    output logic                   headValid,
    output logic [COUNT_WIDTH-1:0] flitCount,
    output logic                   packetDone,
    output logic                   protocolError,
    input  logic                   errorClear
);

    localparam logic [TYPE_WIDTH-1:0] TypeIdle = TYPE_WIDTH'(0);
    localparam logic [TYPE_WIDTH-1:0] TypeHead = TYPE_WIDTH'(1);
    localparam logic [TYPE_WIDTH-1:0] TypeBody = TYPE_WIDTH'(2);
    localparam logic [TYPE_WIDTH-1:0] TypeTail = TYPE_WIDTH'(3);

    typedef enum logic [0:0] {StIdle, StInPacket} state_e;

    state_e                 stateQ, stateD;
    logic                   accept, forward, newError;
    logic                   validD, doneD, errorD;
    logic [DEST_WIDTH-1:0]  destD;
    logic [SRC_WIDTH-1:0]   srcD;
    logic [COUNT_WIDTH-1:0] countD, countInc;

    assign ready_in  = !valid_out || ready_out;
    assign accept    = valid_in && ready_in;
    assign forward   = accept && (flitType_in != TypeIdle);
    assign headValid = (stateQ == StInPacket);
    assign countInc  = (flitCount == '1) ? flitCount : flitCount + COUNT_WIDTH'(1);

    always_comb begin
        stateD   = stateQ;
        destD    = headDest;
        srcD     = headSrc;
        countD   = flitCount;
        doneD    = 1'b0;
        newError = 1'b0;
        validD   = forward ? 1'b1 : (ready_out ? 1'b0 : valid_out);
        if (accept) begin
            unique case (flitType_in)
                TypeHead: begin
                    // A head inside an open packet is an error but restarts the packet.
                    newError = (stateQ == StInPacket);
                    destD    = flit_in[DEST_LSB +: DEST_WIDTH];
                    srcD     = flit_in[SRC_LSB +: SRC_WIDTH];
                    countD   = COUNT_WIDTH'(1);
                    stateD   = StInPacket;
                end
                TypeBody: begin
                    if (stateQ == StInPacket) countD = countInc;
                    else newError = 1'b1;
                end
                TypeTail: begin
                    if (stateQ == StInPacket) begin
                        countD = countInc;
                        doneD  = 1'b1;
                        stateD = StIdle;
                    end else begin
                        newError = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // A new error takes priority over a simultaneous clear.
        errorD = newError || (protocolError && !errorClear);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ        <= StIdle;
            flit_out      <= '0;
            flitType_out  <= '0;
            valid_out     <= 1'b0;
            headDest      <= '0;
            headSrc       <= '0;
            flitCount     <= '0;
            packetDone    <= 1'b0;
            protocolError <= 1'b0;
        end else begin
            stateQ        <= stateD;
            valid_out     <= validD;
            headDest      <= destD;
            headSrc       <= srcD;
            flitCount     <= countD;
            packetDone    <= doneD;
            protocolError <= errorD;
            if (forward) begin
                flit_out     <= flit_in;
                flitType_out <= flitType_in;
            end
        end
    end

endmodule

// File: tb/tb_head_flit_extractor.sv
// Directed and random checks of head_flit_extractor against a packet-level
// reference model; a second instance with a 2-bit counter checks saturation.
module tb_head_flit_extractor;

    localparam logic [1:0] TIdle = 2'd0;
    localparam logic [1:0] THead = 2'd1;
    localparam logic [1:0] TBody = 2'd2;
    localparam logic [1:0] TTail = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] flit_in = '0;
    logic [1:0]  flitType_in = '0;
    logic        valid_in = 1'b0;
    logic        ready_out = 1'b1;
    logic        errorClear = 1'b0;

    logic        ready_in, valid_out, headValid, packetDone, protocolError;
    logic [31:0] flit_out;
    logic [1:0]  flitType_out;
    logic [3:0]  headDest, headSrc;
    logic [7:0]  flitCount;

    logic        sReadyIn, sValidOut, sHeadValid, sPacketDone, sProtocolError;
    logic [31:0] sFlitOut;
    logic [1:0]  sFlitTypeOut;
    logic [3:0]  sHeadDest, sHeadSrc;
    logic [1:0]  sFlitCount;

    int nAssert = 0;
    int nFail   = 0;

    // Reference model state: what the downstream side should see.
    logic        mValid, mDone, mErr, mOpen;
    logic [31:0] mFlit;
    logic [1:0]  mType;
    logic [3:0]  mDest, mSrc;
    int          mCount;

    always #5 clk = ~clk;

    head_flit_extractor dut (
        .clk(clk), .rst_n(rst_n), .flit_in(flit_in), .flitType_in(flitType_in),
        .valid_in(valid_in), .ready_in(ready_in), .flit_out(flit_out),
        .flitType_out(flitType_out), .valid_out(valid_out), .ready_out(ready_out),
        .headDest(headDest), .headSrc(headSrc), .headValid(headValid),
        .flitCount(flitCount), .packetDone(packetDone), .protocolError(protocolError),
        .errorClear(errorClear)
    );

    head_flit_extractor #(.COUNT_WIDTH(2)) dutSmall (
        .clk(clk), .rst_n(rst_n), .flit_in(flit_in), .flitType_in(flitType_in),
        .valid_in(valid_in), .ready_in(sReadyIn), .flit_out(sFlitOut),
        .flitType_out(sFlitTypeOut), .valid_out(sValidOut), .ready_out(ready_out),
        .headDest(sHeadDest), .headSrc(sHeadSrc), .headValid(sHeadValid),
        .flitCount(sFlitCount), .packetDone(sPacketDone), .protocolError(sProtocolError),
        .errorClear(errorClear)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mValid = 0; mDone = 0; mErr = 0; mOpen = 0;
        mFlit = '0; mType = '0; mDest = '0; mSrc = '0; mCount = 0;
    endtask

    task automatic checkAll();
        logic [7:0] expCount;
        logic [1:0] expSmall;
        expCount = (mCount > 255) ? 8'd255 : 8'(mCount);
        expSmall = (mCount > 3) ? 2'd3 : 2'(mCount);
        chk("valid_out", {63'b0, valid_out}, {63'b0, mValid});
        chk("flit_out", {32'b0, flit_out}, {32'b0, mFlit});
        chk("flitType_out", {62'b0, flitType_out}, {62'b0, mType});
        chk("headValid", {63'b0, headValid}, {63'b0, mOpen});
        chk("headDest", {60'b0, headDest}, {60'b0, mDest});
        chk("headSrc", {60'b0, headSrc}, {60'b0, mSrc});
        chk("flitCount", {56'b0, flitCount}, {56'b0, expCount});
        chk("packetDone", {63'b0, packetDone}, {63'b0, mDone});
        chk("protocolError", {63'b0, protocolError}, {63'b0, mErr});
        chk("small.flitCount", {62'b0, sFlitCount}, {62'b0, expSmall});
        chk("small.valid_out", {63'b0, sValidOut}, {63'b0, mValid});
    endtask

    // Drive one cycle of inputs, check ready_in, advance the model and check outputs.
    task automatic step(input logic v, input logic [1:0] t, input logic [31:0] f,
                        input logic r, input logic c);
        logic expReady, acc, err;
        valid_in = v; flitType_in = t; flit_in = f; ready_out = r; errorClear = c;
        #1;
        expReady = !mValid || r;
        chk("ready_in", {63'b0, ready_in}, {63'b0, expReady});
        acc  = v && expReady;
        err  = 0;
        mDone = 0;
        if (acc && t != TIdle) begin
            mValid = 1; mFlit = f; mType = t;
        end else if (r) begin
            mValid = 0;
        end
        if (acc) begin
            case (t)
                THead: begin
                    err = mOpen; mOpen = 1; mDest = f[3:0]; mSrc = f[7:4]; mCount = 1;
                end
                TBody: if (mOpen) mCount++; else err = 1;
                TTail: if (mOpen) begin mCount++; mDone = 1; mOpen = 0; end else err = 1;
                default: ;
            endcase
        end
        mErr = err ? 1'b1 : (c ? 1'b0 : mErr);
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic doReset();
        rst_n = 0; valid_in = 0; errorClear = 0;
        #1;
        modelReset();
        checkAll();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        modelReset();
        #1;
        checkAll();
        @(posedge clk);
        #1;
        rst_n = 1;

        // Clean packet with ready_out held high.
        step(1, THead, 32'h0000_00A3, 1, 0);
        step(1, TBody, 32'h1111_1111, 1, 0);
        step(1, TBody, 32'h2222_2222, 1, 0);
        step(1, TTail, 32'h3333_3333, 1, 0);
        chk("pkt1.headDest", {60'b0, headDest}, 64'h3);
        chk("pkt1.headSrc", {60'b0, headSrc}, 64'hA);
        chk("pkt1.flitCount", {56'b0, flitCount}, 64'd4);
        chk("pkt1.smallCount", {62'b0, sFlitCount}, 64'd3);
        step(0, TIdle, 32'h0, 1, 0);

        // Same packet with a 3-cycle stall mid-packet.
        step(1, THead, 32'h0000_00A3, 1, 0);
        step(1, TBody, 32'h1111_1111, 1, 0);
        for (int i = 0; i < 3; i++) step(1, TBody, 32'h2222_2222, 0, 0);
        chk("stall.flit_out", {32'b0, flit_out}, 64'h1111_1111);
        step(1, TBody, 32'h2222_2222, 1, 0);
        step(1, TTail, 32'h3333_3333, 1, 0);
        chk("stall.flitCount", {56'b0, flitCount}, 64'd4);
        step(1, TIdle, 32'hDEAD_BEEF, 1, 0);

        // Body in IDLE, then clear the error.
        step(1, TBody, 32'h4444_4444, 1, 0);
        chk("idleBody.err", {63'b0, protocolError}, 64'd1);
        step(0, TIdle, 32'h0, 1, 1);
        chk("idleBody.cleared", {63'b0, protocolError}, 64'd0);

        // Head inside an open packet restarts it.
        step(1, THead, 32'h0000_0012, 1, 0);
        step(1, TBody, 32'h5555_5555, 1, 0);
        step(1, THead, 32'h0000_0057, 1, 0);
        step(1, TTail, 32'h6666_6666, 1, 1);
        chk("reHead.headDest", {60'b0, headDest}, 64'h7);
        chk("reHead.headSrc", {60'b0, headSrc}, 64'h5);
        chk("reHead.flitCount", {56'b0, flitCount}, 64'd2);
        step(0, TIdle, 32'h0, 1, 1);

        // Saturation of the narrow counter.
        step(1, THead, 32'h0000_0021, 1, 0);
        for (int i = 0; i < 5; i++) step(1, TBody, 32'h7000_0000 + i, 1, 0);
        chk("sat.smallCount", {62'b0, sFlitCount}, 64'd3);
        chk("sat.flitCount", {56'b0, flitCount}, 64'd6);

        // Reset mid-packet with a flit held, then a body raises the error.
        step(1, TBody, 32'h8888_8888, 0, 0);
        doReset();
        step(1, TBody, 32'h9999_9999, 1, 0);
        chk("postReset.err", {63'b0, protocolError}, 64'd1);

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            logic [1:0] t;
            int         sel;
            sel = int'($urandom_range(0, 9));
            t   = (sel == 0) ? TIdle : (sel < 3) ? THead : (sel < 8) ? TBody : TTail;
            if ($urandom_range(0, 299) == 0) doReset();
            else step($urandom_range(0, 3) != 0, t, $urandom, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 15) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
